// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RISC-V control FSM.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_WB_MEM   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_ALU   = 4'd9,
    S_BRANCH   = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  function automatic state_t decode_next(input logic [6:0] opcode);
    state_t nxt;
    case (opcode)
      LW, SW:  nxt = S_MEM_ADDR;
      R_TYPE:  nxt = S_EXEC_R;
      I_TYPE:  nxt = S_EXEC_I;
      BR:      nxt = S_BRANCH;
      default: nxt = S_ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control unit: Moore-decoded datapath controls with a
// few Mealy qualifiers on memory completion and branch outcome.
module multicycle_ctrl
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Opcode,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       MemReq,
  output logic       MemWe,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSource,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_t state, state_next;
  logic   illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == S_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    MemReq     = 1'b0;
    MemWe      = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSource   = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUOp      = ALU_ADD;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    instr_done = 1'b0;

    case (state)
      S_IDLE: state_next = S_FETCH;

      S_FETCH: begin
        MemReq  = 1'b1;
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_FOUR;
        ALUOp   = ALU_ADD;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end
      end

      // Target is computed from the old PC while the next state is chosen.
      S_DECODE: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALU_ADD;
        state_next = decode_next(Opcode);
      end

      S_MEM_ADDR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALU_ADD;
        state_next = (Opcode == LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        if (mem_ready) state_next = S_WB_MEM;
      end

      S_MEM_WR: begin
        MemReq = 1'b1;
        MemWe  = 1'b1;
        IorD   = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
      end

      S_WB_MEM: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end

      S_EXEC_R: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUOp      = ALU_R;
        state_next = S_WB_ALU;
      end

      S_EXEC_I: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALU_I;
        state_next = S_WB_ALU;
      end

      S_WB_ALU: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUOp      = ALU_BR;
        PCSource   = 1'b1;
        PCWrite    = Zero;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end

      S_ILLEGAL: state_next = S_ILLEGAL;

      default: state_next = S_IDLE;
    endcase
  end

  assign illegal = illegal_q;
  assign state_o = state;

endmodule
